// File: rtl/mem_access_stage.sv
// MEM stage of a five-stage pipeline. Holds one EX/MEM op at a time, issues
// at most one data-memory request for aligned loads/stores, and produces a
// single-cycle MEM/WB pulse for every accepted op (ALU result, load data,
// store completion or misalignment report).
//
// Handshakes: an op is accepted on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE. A memory request holds dmem_req and all
// dmem_* fields stable until the cycle dmem_ack is high; the request
// completes on that edge. dmem_ack outside BUSY is ignored.
module mem_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  ex_mem_rd,
    output logic        ex_mem_reg_write,
    output logic [31:0] ex_mem_data,
    output logic        load_pending,
    output logic        mem_wb_valid,
    output logic [4:0]  mem_wb_rd,
    output logic        mem_wb_reg_write,
    output logic [31:0] mem_wb_data,
    output logic        misalign_err,
    output logic        fsm_state
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state;
    state_t      state_next;

    logic        accept;
    logic        in_mem;
    logic        in_mis;

    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [4:0]  cap_rd;
    logic [2:0]  cap_f3;
    logic        cap_mem_read;
    logic        cap_mem_write;
    logic        cap_reg_write;
    logic        cap_mis;
    logic        pend;

    logic [31:0] shifted;
    logic [31:0] load_data;
    logic        wb_reg_write;

    // funct3[1:0]: 0 = byte, 1 = half, 2/3 = word (covers 3, 6, 7 as word)
    assign accept = in_valid && (state == IDLE);
    assign in_mem = mem_read || mem_write;
    assign in_mis = in_mem && ((funct3[1:0] == 2'd1) ? alu_result[0]
                             : (funct3[1:0] == 2'd0) ? 1'b0
                             : (alu_result[1:0] != 2'b00));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: aligned memory ops go BUSY straight from the capture edge
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && in_mem && !in_mis) state_next = BUSY;
            BUSY: if (dmem_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state and the held EX/MEM op
    always_comb begin
        in_ready         = (state == IDLE);
        fsm_state        = state;
        dmem_req         = 1'b0;
        dmem_we          = 1'b0;
        dmem_addr        = 32'd0;
        dmem_wdata       = 32'd0;
        dmem_wstrb       = 4'd0;
        load_pending     = 1'b0;
        ex_mem_rd        = 5'd0;
        ex_mem_data      = 32'd0;
        ex_mem_reg_write = 1'b0;
        if (state == BUSY) begin
            dmem_req     = 1'b1;
            dmem_we      = cap_mem_write;
            dmem_addr    = {cap_addr[31:2], 2'b00};
            load_pending = cap_mem_read;
            case (cap_f3[1:0])
                2'd0: begin
                    dmem_wstrb = 4'b0001 << cap_addr[1:0];
                    dmem_wdata = {4{cap_wdata[7:0]}};
                end
                2'd1: begin
                    dmem_wstrb = cap_addr[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata = {2{cap_wdata[15:0]}};
                end
                default: begin
                    dmem_wstrb = 4'b1111;
                    dmem_wdata = cap_wdata;
                end
            endcase
        end
        if ((state == BUSY) || pend) begin
            ex_mem_rd        = cap_rd;
            ex_mem_data      = cap_addr;
            ex_mem_reg_write = cap_reg_write && !cap_mem_read && (cap_rd != 5'd0);
        end
    end

    // Load data alignment and sign/zero extension
    always_comb begin
        shifted = dmem_rdata >> {cap_addr[1:0], 3'b000};
        case (cap_f3[1:0])
            2'd0:    load_data = cap_f3[2] ? {24'd0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = cap_f3[2] ? {16'd0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    assign wb_reg_write = cap_reg_write && (cap_rd != 5'd0) && !cap_mem_write;

    // EX/MEM capture; pend marks the cycle right after a capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_addr      <= 32'd0;
            cap_wdata     <= 32'd0;
            cap_rd        <= 5'd0;
            cap_f3        <= 3'd0;
            cap_mem_read  <= 1'b0;
            cap_mem_write <= 1'b0;
            cap_reg_write <= 1'b0;
            cap_mis       <= 1'b0;
            pend          <= 1'b0;
        end else begin
            pend <= accept;
            if (accept) begin
                cap_addr      <= alu_result;
                cap_wdata     <= rs2_data;
                cap_rd        <= rd;
                cap_f3        <= funct3;
                cap_mem_read  <= mem_read;
                cap_mem_write <= mem_write;
                cap_reg_write <= reg_write;
                cap_mis       <= in_mis;
            end
        end
    end

    // MEM/WB register: single-cycle valid/error pulses, rd/data hold between
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wb_valid     <= 1'b0;
            mem_wb_rd        <= 5'd0;
            mem_wb_reg_write <= 1'b0;
            mem_wb_data      <= 32'd0;
            misalign_err     <= 1'b0;
        end else begin
            mem_wb_valid <= 1'b0;
            misalign_err <= 1'b0;
            if ((state == BUSY) && dmem_ack) begin
                mem_wb_valid     <= 1'b1;
                mem_wb_rd        <= cap_rd;
                mem_wb_reg_write <= wb_reg_write;
                mem_wb_data      <= cap_mem_read ? load_data : cap_addr;
            end else if (pend && !(cap_mem_read || cap_mem_write)) begin
                mem_wb_valid     <= 1'b1;
                mem_wb_rd        <= cap_rd;
                mem_wb_reg_write <= wb_reg_write;
                mem_wb_data      <= cap_addr;
            end else if (pend && cap_mis) begin
                mem_wb_valid     <= 1'b1;
                mem_wb_rd        <= cap_rd;
                mem_wb_reg_write <= 1'b0;
                mem_wb_data      <= cap_addr;
                misalign_err     <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-003 SHALL have ports: in_valid  in  1 / in_ready  out  1  EX-to-MEM handshake.
REQ-004 SHALL have ports: alu_result  in  32  address or result; rs2_data  in  32  store data; rd  in  5; funct3  in  3; mem_read, mem_write, reg_write  in  1 each.
REQ-005 SHALL have ports: dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32; dmem_wstrb  out  4; dmem_ack  in  1; dmem_rdata  in  32.
REQ-006 SHALL have ports: ex_mem_rd  out  5; ex_mem_reg_write  out  1; ex_mem_data  out  32; load_pending  out  1 (forwarding/hazard taps).
REQ-007 SHALL have ports: mem_wb_valid  out  1; mem_wb_rd  out  5; mem_wb_reg_write  out  1; mem_wb_data  out  32; misalign_err  out  1.

Function
REQ-008 SHALL implement FSM states IDLE and BUSY; in_ready = 1 only in IDLE.
REQ-009 SHALL capture all inputs into an internal EX/MEM register on a clock edge with in_valid && in_ready.
REQ-010 SHALL, for a captured op with mem_read = mem_write = 0, present it on mem_wb_* with mem_wb_valid = 1 on the next edge; FSM stays IDLE; data = alu_result.
REQ-011 SHALL, for a captured aligned load/store, enter BUSY and hold dmem_req = 1 with stable dmem_we/addr/wdata/wstrb until the cycle dmem_ack = 1.
REQ-012 SHALL, on the dmem_ack cycle, return to IDLE and set mem_wb_valid = 1 on that edge; the same edge SHALL NOT accept a new input.
REQ-013 SHALL set dmem_addr = {alu_result[31:2], 2'b00} and dmem_we = mem_write.
REQ-014 SHALL set stores with SB: wstrb = 1 << addr[1:0], wdata = byte replicated x4; SH: wstrb = 0011 or 1100 by addr[1], wdata = half replicated x2; SW: wstrb = 1111.
REQ-015 SHALL extract load data from dmem_rdata by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-016 SHALL treat funct3 values 3, 6, 7 on memory ops as LW/SW.
REQ-017 SHALL detect misalignment (half with addr[0]=1; word with addr[1:0]!=0): no dmem_req, stay IDLE, emit mem_wb_valid = 1, mem_wb_reg_write = 0, misalign_err = 1 for one cycle.
REQ-018 SHALL force mem_wb_reg_write = 0 when rd = 0 or the op is a store.
REQ-019 SHALL drive mem_wb_valid and misalign_err as single-cycle pulses; mem_wb_rd/data hold until the next pulse.
REQ-020 SHALL drive ex_mem_rd = captured rd, ex_mem_data = captured alu_result, and ex_mem_reg_write = captured reg_write && !mem_read && rd!=0, while the stage holds an op (in BUSY, or in the cycle after capture); otherwise 0.
REQ-021 SHALL assert load_pending = 1 while a load is held in BUSY.
REQ-022 SHALL ignore dmem_ack while in IDLE.
REQ-023 SHALL NOT issue more than one outstanding memory request.

Reset
REQ-024 SHALL, on reset = 0 at any time, force FSM to IDLE and all outputs to 0 except in_ready = 1, abandoning any in-flight request (dmem_req drops asynchronously).
REQ-025 SHALL resume normal capture on the first rising edge after reset returns to 1.

Verification
REQ-026 SHALL pass: ALU op alu_result=0x1234, rd=5, reg_write=1 -> next edge mem_wb_valid=1, mem_wb_rd=5, mem_wb_data=0x1234, mem_wb_reg_write=1.
REQ-027 SHALL pass: LB addr=0x103, dmem_rdata=0x80FF_0000, ack after 3 cycles -> in_ready=0 for 3 cycles, load_pending=1, mem_wb_data=0xFFFF_FF80.
REQ-028 SHALL pass: SH addr=0x102, rs2_data=0xABCD_1234 -> dmem_we=1, dmem_wstrb=1100, dmem_wdata=0x1234_1234, mem_wb_reg_write=0.
REQ-029 SHALL pass: LW addr=0x101 -> no dmem_req, misalign_err=1 one cycle, mem_wb_reg_write=0.
REQ-030 SHALL pass: reset=0 mid-BUSY -> dmem_req=0 immediately, in_ready=1, mem_wb_valid=0; a later dmem_ack is ignored.
REQ-031 SHALL pass: LW rd=0 ack with 0xDEAD_BEEF -> mem_wb_valid=1, mem_wb_reg_write=0.
